temp_report_ctrl: RTL
=====================

# temp_report_ctrl

Frame sequencer for the board's UART transmit path. It latches the 7-bit temperature reading and converts it to three ASCII decimal digits. It then feeds a 6-byte report frame ("T", hundreds, tens, ones, CR, LF) to the byte-level UART transmitter over a valid/ready handshake. Frames start on an explicit start pulse or on a free-running period timer; triggers that arrive during a frame are queued one deep.

## Interface
- PERIOD_CYCLES, 50_000_000, clock cycles between automatic reports (1 s at 50 MHz); 0 disables the periodic trigger
- clk  input  1  system clock, 50 MHz
- nRST  input  1  reset, asynchronous, active-low
- start  input  1  request one report; sampled high on a clk rising edge
- temp  input  7  temperature reading, unsigned 0..127
- tx_data  output  8  byte presented to UART transmitter
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  transmitter accepts tx_data this edge
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted

## Operation
- States: IDLE, CONV, SEND, DONE.
- Trigger = start OR period tick.
  - Period tick: a free-running counter counts 0..PERIOD_CYCLES-1, wraps to 0, and asserts tick for the cycle it holds PERIOD_CYCLES-1.
  - The counter runs in every state.
- IDLE: on trigger or pending, latch temp into temp_q, clear pending, go to CONV.
- CONV (1 cycle): compute h = temp_q/100, t = (temp_q%100)/10, o = temp_q%10. Store the bytes 0x54, 0x30+h, 0x30+t, 0x30+o, 0x0D, 0x0A. Clear byte index, go to SEND.
- SEND: drive tx_valid=1 and tx_data = byte[idx].
  - A transfer occurs on an edge with tx_valid && tx_ready.
  - On a transfer with idx<5: idx++ and tx_valid stays high, so back-to-back transfers are allowed.
  - On a transfer with idx==5: go to DONE.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- DONE (1 cycle): frame_done=1, tx_valid=0. Next state is CONV (latching temp again) if pending or a trigger is present this cycle; otherwise IDLE.
- Trigger while not in IDLE: sets pending. Multiple triggers collapse into one pending report, and a pending flag already set stays set.
- temp is sampled only at the IDLE/DONE→CONV edge. Changes during a frame do not affect that frame.
- busy = (state != IDLE).

## Timing
- Reset values: tx_data=0x00, tx_valid=0, busy=0, frame_done=0, state=IDLE, period counter=0, pending=0, idx=0.
- Reset mid-frame aborts immediately (asynchronous): tx_valid falls without waiting for a handshake, and the partial frame is not resumed after reset.
- With start high at edge N and tx_ready held 1:
  - Edge N: busy=1.
  - After edge N+1: tx_valid=1, tx_data=0x54.
  - Edges N+2..N+7: bytes transferred.
  - After edge N+7: frame_done=1 for one cycle.
  - Edge N+8: busy=0 (if nothing pending).
  - Minimum frame is 8 cycles, trigger edge to busy falling.
- Each cycle of tx_ready=0 in SEND adds exactly one cycle of latency.
- Simultaneous start and period tick in IDLE produce one frame only; pending is not set.
- Trigger in DONE goes directly to CONV with no IDLE cycle; busy stays high.

## Test plan
- Reset, tx_ready=1, temp=72, pulse start one cycle:
  - Required bytes: 0x54, 0x30, 0x37, 0x32, 0x0D, 0x0A on consecutive edges.
  - frame_done high for exactly one cycle; busy high for 8 cycles.
- Boundary temps 0, 9, 10, 99, 100, 127:
  - Digits required: "000", "009", "010", "099", "100", "127".
- tx_ready backpressure: toggle tx_ready pseudo-randomly during a frame with temp=105.
  - tx_data stays stable while stalled.
  - Exactly six transfers, in order; no byte duplicated or dropped.
- PERIOD_CYCLES=20, start held low:
  - Frames begin every 20 cycles.
  - Two start pulses mid-frame yield exactly one extra frame, which begins in the cycle after DONE.
  - temp changed mid-frame to 33 appears only in the next frame.
- Assert nRST=0 during byte 3 of a frame:
  - tx_valid, busy and frame_done go 0 without a clock edge.
  - After release, no output activity until the next trigger, which yields a complete fresh frame.
- PERIOD_CYCLES=0, no start for 1000 cycles:
  - tx_valid remains 0 throughout.

Source files
------------

// File: rtl/temp_report_ctrl.sv
// temp_report_ctrl: builds a 6-byte ASCII temperature report ("T", three
// decimal digits, CR, LF) and streams it to a byte UART over valid/ready.
// A report starts on a start pulse or a periodic tick. One trigger that
// arrives during a frame is held and starts the next frame.
module temp_report_ctrl #(
  parameter int unsigned PERIOD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       start,
  input  logic [6:0] temp,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CNT_W     = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned DIG_W     = 24;
  localparam bit          PERIOD_EN = (PERIOD_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(5);

  typedef enum logic [1:0] {IDLE, CONV, SEND, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic               pending, pending_n;
  logic [6:0]         temp_q, temp_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [DIG_W-1:0]   dig_q, dig_n;
  logic [7:0]         tx_data_n;
  logic               tx_valid_n, busy_n, frame_done_n;
  logic               tick_c, trigger_c;
  logic [6:0]         hund_c, tens_c, ones_c;

  // Byte at position i of the frame; digit bytes come from d (hundreds MSB).
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i,
                                            input logic [DIG_W-1:0] d);
    case (i)
      3'd0:    frame_byte = 8'h54;
      3'd1:    frame_byte = d[23:16];
      3'd2:    frame_byte = d[15:8];
      3'd3:    frame_byte = d[7:0];
      3'd4:    frame_byte = 8'h0D;
      default: frame_byte = 8'h0A;
    endcase
  endfunction

  // Free-running period counter; runs in every state.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (!PERIOD_EN || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c    = PERIOD_EN && (cnt == CNT_LAST);
  assign trigger_c = start | tick_c;

  // Decimal split of the latched reading.
  always_comb begin
    hund_c = temp_q / 7'd100;
    tens_c = (temp_q % 7'd100) / 7'd10;
    ones_c = temp_q % 7'd10;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    temp_n    = temp_q;
    idx_n     = idx;
    dig_n     = dig_q;
    tx_data_n = tx_data;

    case (state)
      IDLE: begin
        if (trigger_c || pending) begin
          temp_n    = temp;
          pending_n = 1'b0;
          state_n   = CONV;
        end
      end
      CONV: begin
        if (trigger_c) pending_n = 1'b1;
        dig_n   = {8'h30 + 8'(hund_c), 8'h30 + 8'(tens_c), 8'h30 + 8'(ones_c)};
        idx_n   = '0;
        state_n = SEND;
      end
      SEND: begin
        if (trigger_c) pending_n = 1'b1;
        if (tx_valid && tx_ready) begin
          if (idx == IDX_LAST) begin
            state_n = DONE;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (trigger_c || pending) begin
          temp_n    = temp;
          pending_n = 1'b0;
          state_n   = CONV;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n       = (state_n != IDLE);
    tx_valid_n   = (state_n == SEND);
    frame_done_n = (state_n == DONE);
    if (state_n == SEND) tx_data_n = frame_byte(idx_n, dig_n);
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      pending    <= 1'b0;
      temp_q     <= '0;
      idx        <= '0;
      dig_q      <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      temp_q     <= temp_n;
      idx        <= idx_n;
      dig_q      <= dig_n;
      tx_data    <= tx_data_n;
      tx_valid   <= tx_valid_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule
